// File: rtl/lsu_mem_port.sv
// Load/store port for a single-ported word memory; sub-word stores use read-modify-write.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_mem_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_ce,
  output logic        mem_we,
  output logic        mem_memRr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wtData,
  output logic [3:0]  mem_w_mask,
  output logic [3:0]  mem_r_mask,
  input  logic [31:0] mem_rdData
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic        store_q;
  logic [15:0] wdata_q;
  logic        misalign;
  logic        is_byte;
  logic        is_half;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merge_val;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (req_size == 2'b01 && req_addr[0]) ||
                    (req_size[1] && req_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      resp_err <= 1'b0;
    else if (req_valid && req_ready)
      resp_err <= misalign;
  end
`else
  assign misalign = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign req_ready  = (state == IDLE);
  assign mem_w_mask = {4{mem_we}};
  assign mem_r_mask = {4{mem_memRr}};

  assign is_byte  = (size_q == 2'b00);
  assign is_half  = (size_q == 2'b01);
  assign byte_sel = mem_rdData[{lane_q, 3'b000} +: 8];
  assign half_sel = lane_q[1] ? mem_rdData[31:16] : mem_rdData[15:0];

  always_comb begin
    load_val = mem_rdData;
    unique case (1'b1)
      is_byte: load_val = {{24{signed_q & byte_sel[7]}}, byte_sel};
      is_half: load_val = {{16{signed_q & half_sel[15]}}, half_sel};
      default: load_val = mem_rdData;
    endcase
  end

  // Only the addressed lane of the fetched word is replaced.
  always_comb begin
    merge_val = mem_rdData;
    unique case (1'b1)
      is_byte: merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
      is_half: merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_q;
      default: merge_val = mem_rdData;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lane_q     <= 2'b00;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      store_q    <= 1'b0;
      wdata_q    <= 16'h0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      mem_ce     <= 1'b0;
      mem_we     <= 1'b0;
      mem_memRr  <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wtData <= 32'h0;
    end else begin
      resp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            lane_q   <= req_addr[1:0];
            size_q   <= req_size;
            signed_q <= req_signed;
            store_q  <= req_is_store;
            wdata_q  <= req_wdata[15:0];
            if (misalign) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= 32'h0;
            end else if (req_is_store && req_size[1]) begin
              state      <= WR;
              mem_ce     <= 1'b1;
              mem_we     <= 1'b1;
              mem_addr   <= {req_addr[31:2], 2'b00};
              mem_wtData <= req_wdata;
            end else begin
              state     <= RD;
              mem_ce    <= 1'b1;
              mem_memRr <= 1'b1;
              mem_addr  <= {req_addr[31:2], 2'b00};
            end
          end
        end
        RD: begin
          mem_memRr <= 1'b0;
          if (store_q) begin
            state      <= WR;
            mem_we     <= 1'b1;
            mem_wtData <= merge_val;
          end else begin
            state      <= RESP;
            mem_ce     <= 1'b0;
            mem_addr   <= 32'h0;
            resp_valid <= 1'b1;
            resp_rdata <= load_val;
          end
        end
        WR: begin
          state      <= RESP;
          mem_ce     <= 1'b0;
          mem_we     <= 1'b0;
          mem_addr   <= 32'h0;
          mem_wtData <= 32'h0;
          resp_valid <= 1'b1;
          resp_rdata <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Scoreboard bench for lsu_mem_port with a small behavioural word memory.
module tb_lsu_mem_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_ce;
  logic        mem_we;
  logic        mem_memRr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wtData;
  logic [3:0]  mem_w_mask;
  logic [3:0]  mem_r_mask;
  logic [31:0] mem_rdData;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  exp_t        sb[$];
  wr_t         wq[$];
  logic [31:0] mem [4];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_resp = -100;
  logic        loaded = 1'b0;
  logic        arm = 1'b0;
  logic        we_seen = 1'b0;
  logic        ce_seen = 1'b0;
  int          acc1;
  int          acc2;

  lsu_mem_port dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_store(req_is_store), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_memRr(mem_memRr),
    .mem_addr(mem_addr), .mem_wtData(mem_wtData),
    .mem_w_mask(mem_w_mask), .mem_r_mask(mem_r_mask),
    .mem_rdData(mem_rdData)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  assign mem_rdData = mem[mem_addr[3:2]];

  always @(posedge clk) begin
    if (!loaded) begin
      mem[0] <= 32'h19D29AB9;
      mem[1] <= 32'hDB1A18E4;
      mem[2] <= 32'h0;
      mem[3] <= 32'h0;
    end else if (mem_ce && mem_we) begin
      if (wq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write actual=%h required=none", mem_wtData);
      end else begin
        wr_t w;
        w = wq.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_wtData, w.data);
      end
      mem[mem_addr[3:2]] <= mem_wtData;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (arm && mem_we) we_seen = 1'b1;
    if (arm && mem_ce) ce_seen = 1'b1;
  end

  always @(negedge clk) begin
    if (resp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=1 required=0");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", 32'(resp_err), 32'(e.err));
        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        last_resp = cyc;
      end
    end
    if (!mem_ce)
      chk("mem_idle", 32'({mem_we, mem_memRr, |mem_addr, |mem_wtData}), 32'h0);
    else
      chk("mem_addr_lsb", 32'(mem_addr[1:0]), 32'h0);
    chk("w_mask", 32'(mem_w_mask), 32'({4{mem_we}}));
    chk("r_mask", 32'(mem_r_mask), 32'({4{mem_memRr}}));
  end

  task automatic issue(input logic st, input logic [1:0] sz,
                       input logic sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] er,
                       input logic ee, input int lat, input logic push,
                       input logic hold, output int acc);
    int n;
    n = 0;
    req_valid    = 1'b1;
    req_is_store = st;
    req_size     = sz;
    req_signed   = sg;
    req_addr     = a;
    req_wdata    = wd;
    while (!req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 32'(req_ready), 32'h1);
    acc = cyc;
    if (push) sb.push_back('{er, ee, cyc, lat});
    @(negedge clk);
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || wq.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size() + wq.size()), 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    loaded = 1'b1;
    chk("rst_ready", 32'(req_ready), 32'h1);
    chk("rst_resp", 32'({resp_valid, resp_err}), 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_mem", 32'({mem_ce, mem_we, mem_memRr, |mem_addr, |mem_wtData}), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(0, 2'b00, 1, 32'h1, 0, 32'hFFFFFF9A, 0, 2, 1, 0, acc1);
    drain();
    issue(0, 2'b01, 0, 32'h2, 0, 32'h000019D2, 0, 2, 1, 0, acc1);
    drain();
    wq.push_back('{32'h0, 32'h55D29AB9});
    issue(1, 2'b00, 0, 32'h3, 32'h55, 32'h0, 0, 3, 1, 0, acc1);
    drain();
    issue(0, 2'b10, 0, 32'h0, 0, 32'h55D29AB9, 0, 2, 1, 0, acc1);
    drain();

    arm = 1'b1;
    ce_seen = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    issue(0, 2'b10, 0, 32'h6, 0, 32'h0, 1, 1, 1, 0, acc1);
    drain();
    chk("trap_no_ce", 32'(ce_seen), 32'h0);
`else
    issue(0, 2'b10, 0, 32'h6, 0, 32'hDB1A18E4, 0, 2, 1, 0, acc1);
    drain();
    chk("noalign_ce", 32'(ce_seen), 32'h1);
`endif
    arm = 1'b0;

    issue(0, 2'b01, 1, 32'h4, 0, 32'h000018E4, 0, 2, 1, 0, acc1);
    drain();
    issue(0, 2'b00, 1, 32'h7, 0, 32'hFFFFFFDB, 0, 2, 1, 0, acc1);
    drain();
    issue(0, 2'b00, 0, 32'h6, 0, 32'h0000001A, 0, 2, 1, 0, acc1);
    drain();
    wq.push_back('{32'h4, 32'hBEEF18E4});
    issue(1, 2'b01, 0, 32'h6, 32'h1234BEEF, 32'h0, 0, 3, 1, 0, acc1);
    drain();
    wq.push_back('{32'h4, 32'h12345678});
    issue(1, 2'b10, 0, 32'h4, 32'h12345678, 32'h0, 0, 2, 1, 0, acc1);
    drain();
    issue(0, 2'b10, 0, 32'h4, 0, 32'h12345678, 0, 2, 1, 0, acc1);
    drain();

    arm = 1'b1;
    we_seen = 1'b0;
    issue(1, 2'b01, 0, 32'h0, 32'hAAAA, 32'h0, 0, 3, 0, 0, acc1);
    chk("mid_rd", 32'(mem_memRr), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(mem_we), 32'h0);
    chk("abort_ce", 32'(mem_ce), 32'h0);
    chk("abort_ready", 32'(req_ready), 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    arm = 1'b0;
    chk("abort_no_we", 32'(we_seen), 32'h0);
    chk("abort_word0", mem[0], 32'h55D29AB9);
    chk("abort_ready_after", 32'(req_ready), 32'h1);

    issue(0, 2'b10, 0, 32'h0, 0, 32'h55D29AB9, 0, 2, 1, 1, acc1);
    issue(0, 2'b00, 0, 32'h0, 0, 32'h000000B9, 0, 2, 1, 0, acc2);
    chk("b2b_after_resp", 32'(acc2), 32'(last_resp + 1));
    chk("b2b_gap", 32'(acc2 - acc1), 32'h3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu_mem_port.md
LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; port list, clock and reset first:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  req_valid  in  1  pipeline access request
  req_ready  out  1  port idle, request accepted when req_valid&req_ready
  req_is_store  in  1  1=store, 0=load
  req_size  in  2  00=byte, 01=half, 10=word, 11 treated as word
  req_signed  in  1  sign-extend load result
  req_addr  in  32  byte address
  req_wdata  in  32  store data, right-aligned
  resp_valid  out  1  one-cycle completion pulse
  resp_rdata  out  32  load result, right-aligned and extended
  resp_err  out  1  misaligned access, qualified by resp_valid
  mem_ce  out  1  data memory chip enable
  mem_we  out  1  data memory write enable
  mem_memRr  out  1  data memory read enable
  mem_addr  out  32  word address, low two bits always 00
  mem_wtData  out  32  full word to write
  mem_w_mask  out  4  always 1111 when mem_we=1, else 0000
  mem_r_mask  out  4  always 1111 when mem_memRr=1, else 0000
  mem_rdData  in  32  combinational read data from the data memory

Function
REQ-002 SHALL implement the FSM IDLE, RD, WR, RESP; only IDLE drives req_ready=1.
REQ-003 On accept, SHALL register addr, size, signed, store flag and wdata; req_* inputs SHALL be ignored outside IDLE.
REQ-004 Load: IDLE -> RD (mem_ce=1, mem_memRr=1) -> RESP; mem_rdData SHALL be captured on the rising edge that ends RD.
REQ-005 Word store: IDLE -> WR (mem_ce=1, mem_we=1, mem_wtData=req_wdata) -> RESP.
REQ-006 Byte and half stores SHALL be read-modify-write: IDLE -> RD -> WR -> RESP. WR SHALL write the captured word with only the addressed lane replaced.
REQ-007 Lane selection: byte lane = addr[1:0]; half lane = addr[1] (bits 15:0 or 31:16).
REQ-008 Load extraction: the selected lane SHALL be shifted to bit 0, then zero-extended, or sign-extended when req_signed=1; word loads SHALL pass unchanged.
REQ-009 RESP SHALL last exactly one cycle with resp_valid=1, then return to IDLE.
REQ-010 resp_rdata SHALL hold its value until the next load response; it SHALL be 0 for store responses.
REQ-011 Latency from the accept edge to resp_valid: load 2 cycles, word store 2 cycles, sub-word store 3 cycles, error 1 cycle.
REQ-012 Outside RD and WR, mem_ce, mem_we and mem_memRr SHALL be 0, and mem_addr and mem_wtData SHALL be 0.

Reset
REQ-013 While rst_n=0, SHALL be in IDLE with: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, and every mem_* output 0.
REQ-014 Reset asserted mid-operation SHALL abort the operation immediately: mem_we drops asynchronously, no write is performed, and no response is issued.

Configuration
REQ-015 Macro LSU_MISALIGN_TRAP_EN, when defined, SHALL trap misaligned accesses:
  - misaligned = half with addr[0]=1, or word with addr[1:0]!=00;
  - on a misaligned access: IDLE -> RESP with resp_err=1, mem_ce never asserted.
REQ-016 When LSU_MISALIGN_TRAP_EN is undefined:
  - resp_err SHALL be tied 0;
  - misaligned low address bits SHALL be ignored: half uses addr[1], word ignores addr[1:0].

Verification
REQ-017 The bench SHALL cover these scenarios, with memory word0=0x19D29AB9 and word1=0xDB1A18E4:
  - Signed byte load, addr 0x1 -> resp_valid 2 cycles after accept, resp_rdata=0xFFFFFF9A.
  - Unsigned half load, addr 0x2 -> resp_rdata=0x000019D2.
  - Byte store of 0x55 to addr 0x3 -> RD then WR with mem_wtData=0x55D29AB9 and mem_w_mask=1111, resp_valid on cycle 3; a later word load of 0x0 returns 0x55D29AB9.
  - Word load, addr 0x6 -> with LSU_MISALIGN_TRAP_EN: resp_err=1 after 1 cycle, mem_ce stays 0; without it: resp_rdata=0xDB1A18E4, resp_err=0.
  - Half store to addr 0x0, rst_n pulsed low during RD -> mem_we never asserted, word0 unchanged, no resp_valid, req_ready=1 after reset.
  - req_valid held high back-to-back -> second request accepted only on the cycle after resp_valid.
